fx_quant_sat_pipe: RTL and testbench

- Pipelined signed fixed-point format converter: rounding, then saturation or wrap.
- Valid/ready handshake on both sides; counts overflow events.
- Sits directly upstream of the 12-bit-input format-match stage. Narrows wide accumulator/multiplier results (default Q6.10, 16 b) to that stage's 12-bit input format (default Q4.8).

---
 rtl/fx_quant_sat_pipe.sv | 76 +++++++
 tb/tb_fx_quant_sat_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fx_quant_sat_pipe.sv
// fx_quant_sat_pipe: two-stage signed fixed-point narrowing (round, then saturate or wrap) with valid/ready and overflow counter
// ports: clk/rst (sync, active high); i_valid/i_ready/i_data input handshake;
//        o_valid/o_ready/o_data/o_ovf output handshake with overflow flag;
//        cnt_clr clears ovf_cnt, the saturating count of delivered overflowed samples
module fx_quant_sat_pipe #(
  parameter int IN_W     = 16,
  parameter int IN_FRAC  = 10,
  parameter int OUT_W    = 12,
  parameter int OUT_FRAC = 8,
  parameter int RND_MODE = 1,
  parameter int SAT_MODE = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [IN_W-1:0]  i_data,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_ovf,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt
);
  localparam int SH = IN_FRAC - OUT_FRAC;
  localparam int LS = SH < 0 ? -SH : 0;
  localparam int QW = IN_W + 1 + LS;
  logic signed [QW-1:0] ext, q, s1_q, hi, lo;
  logic                 s1_v, s1_adv, s2_adv, ovf;
  logic [OUT_W-1:0]     res;
  // one extra headroom bit so the rounding add cannot overflow
  assign ext = {{(QW-IN_W){i_data[IN_W-1]}}, i_data};
  generate
    if (SH > 0) begin : g_rs
      logic signed [QW-1:0] sum;
      assign sum = ext + QW'(RND_MODE != 0 ? 2 ** (SH - 1) : 0);
      assign q   = sum >>> SH;
    end else begin : g_ls
      assign q = ext <<< LS;
    end
  endgenerate
  assign hi  = {{(QW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  assign lo  = ~hi;
  assign ovf = s1_q > hi || s1_q < lo;
  assign res = (SAT_MODE != 0 && ovf) ? (s1_q[QW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
                                      : s1_q[OUT_W-1:0];
  assign s2_adv  = !o_valid || o_ready;
  assign s1_adv  = !s1_v || s2_adv;
  assign i_ready = s1_adv;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_q    <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ovf   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_v <= i_valid;
        s1_q <= q;
      end
      if (s2_adv) begin
        o_valid <= s1_v;
        if (s1_v) begin
          o_data <= res;
          o_ovf  <= ovf;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) ovf_cnt <= '0;
    else if (o_valid && o_ready && o_ovf && !(&ovf_cnt)) ovf_cnt <= ovf_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_fx_quant_sat_pipe.sv
// tb_fx_quant_sat_pipe: randomized + directed check of fx_quant_sat_pipe against an arithmetic reference
module tb_fx_quant_sat_pipe;
  logic        clk = 0, rst = 1, i_valid = 0, o_ready = 1, cnt_clr = 0;
  logic [15:0] i_data = '0;
  logic        i_ready0, i_ready1, i_ready2, o_valid0, o_valid1, o_valid2, o_ovf0, o_ovf1, o_ovf2;
  logic [11:0] o_data0, o_data1, o_data2;
  logic [3:0]  ovf_cnt0;
  logic [15:0] ovf_cnt1, ovf_cnt2;
  int          checks = 0, errors = 0;
  logic [15:0] sq[$];
  logic [11:0] obs[$];
  int          m0, m1, m2;
  bit          collect = 0, hold_v = 0;
  logic [11:0] hold_d;
  logic [12:0] r0, r1, r2;
  logic [15:0] x;

  always #5 clk = ~clk;

  fx_quant_sat_pipe #(.RND_MODE(1), .SAT_MODE(1), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready0), .i_data(i_data),
    .o_valid(o_valid0), .o_ready(o_ready), .o_data(o_data0), .o_ovf(o_ovf0),
    .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt0));
  fx_quant_sat_pipe #(.RND_MODE(0), .SAT_MODE(0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready1), .i_data(i_data),
    .o_valid(o_valid1), .o_ready(o_ready), .o_data(o_data1), .o_ovf(o_ovf1),
    .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt1));
  fx_quant_sat_pipe #(.RND_MODE(1), .SAT_MODE(0), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready2), .i_data(i_data),
    .o_valid(o_valid2), .o_ready(o_ready), .o_data(o_data2), .o_ovf(o_ovf2),
    .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Q6.10 -> Q4.8: value in output LSBs is x/4, floored after optional +half-LSB
  function automatic logic [12:0] ref_q(input logic [15:0] xin, input bit rnd, input bit sat);
    int n, v;
    bit ov;
    logic [11:0] d;
    n  = int'($signed(xin)) + (rnd ? 2 : 0);
    v  = n >= 0 ? n / 4 : -((-n + 3) / 4);
    ov = v > 2047 || v < -2048;
    d  = v[11:0];
    if (sat && ov) d = v > 0 ? 12'h7FF : 12'h800;
    return {ov, d};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      sq.delete();
      m0 = 0; m1 = 0; m2 = 0;
      hold_v = 0;
    end else begin
      if (o_valid0 && !o_ready) begin
        if (hold_v) chk("hold", o_data0, hold_d);
        hold_v = 1;
        hold_d = o_data0;
      end else hold_v = 0;
      if (i_valid && i_ready0) sq.push_back(i_data);
      r0 = '0; r1 = '0; r2 = '0;
      if (o_valid0 && o_ready) begin
        if (sq.size() == 0) chk("stale", 1, 0);
        else begin
          x  = sq.pop_front();
          r0 = ref_q(x, 1, 1);
          r1 = ref_q(x, 0, 0);
          r2 = ref_q(x, 1, 0);
          chk("out_r1s1", {o_ovf0, o_data0}, r0);
          chk("out_r0s0", {o_ovf1, o_data1}, r1);
          chk("out_r1s0", {o_ovf2, o_data2}, r2);
          if (collect) obs.push_back(o_data0);
        end
      end
      if (cnt_clr) begin
        m0 = 0; m1 = 0; m2 = 0;
      end else begin
        if (r0[12] && m0 < 15) m0++;
        if (r1[12] && m1 < 65535) m1++;
        if (r2[12] && m2 < 65535) m2++;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("cnt0", ovf_cnt0, m0);
    chk("cnt1", ovf_cnt1, m1);
    chk("cnt2", ovf_cnt2, m2);
  end

  task automatic one(input logic [15:0] d, input logic [11:0] e0, input logic [11:0] e1,
                     input logic [11:0] e2, input logic v0);
    @(negedge clk);
    i_valid = 1; i_data = d; o_ready = 1;
    @(negedge clk);
    i_valid = 0;
    chk("lat_early", o_valid0, 0);
    @(negedge clk);
    chk("lat_valid", o_valid0, 1);
    chk("dir_d0", o_data0, e0);
    chk("dir_d1", o_data1, e1);
    chk("dir_d2", o_data2, e2);
    chk("dir_ovf0", o_ovf0, v0);
  endtask

  initial begin
    int idx, cyc, stale, s;
    bit saw_full;
    repeat (2) @(negedge clk);
    chk("rst_v", {o_valid0, o_valid1, o_valid2}, 0);
    chk("rst_d", o_data0, 0);
    chk("rst_ovf", o_ovf0, 0);
    chk("rst_cnt", ovf_cnt0, 0);
    rst = 0;
    #1 chk("rst_rdy", {i_ready0, i_ready1, i_ready2}, 3'b111);

    one(16'h0006, 12'h002, 12'h001, 12'h002, 0);
    one(16'hFFFA, 12'hFFF, 12'hFFE, 12'hFFF, 0);
    one(16'd8189, 12'h7FF, 12'h7FF, 12'h7FF, 0);
    one(16'd8190, 12'h7FF, 12'h7FF, 12'h800, 1);
    one(16'h7FFF, 12'h7FF, 12'hFFF, 12'h000, 1);
    one(16'h8000, 12'h800, 12'h000, 12'h000, 1);

    // backpressure: samples 1..8, stall output for cycles 3..5
    @(negedge clk);
    idx = 0; cyc = 0; saw_full = 0; collect = 1; obs.delete();
    while ((idx < 8 || obs.size() < 8) && cyc < 60) begin
      i_valid = idx < 8;
      i_data  = 16'((idx + 1) << 2);
      o_ready = !(cyc >= 3 && cyc < 6);
      #1;
      if (!i_ready0) saw_full = 1;
      if (cyc == 2) chk("stream_lat", {o_valid0, o_data0}, {1'b1, 12'd1});
      @(posedge clk);
      if (i_valid && i_ready0) idx++;
      cyc++;
      @(negedge clk);
    end
    i_valid = 0; o_ready = 1; collect = 0;
    chk("bp_full", saw_full, 1);
    chk("bp_count", obs.size(), 8);
    for (int k = 0; k < 8 && k < obs.size(); k++) chk("bp_order", obs[k], k + 1);

    // counter saturation with CNT_W = 4
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
    i_valid = 1; i_data = 16'h7FFF;
    repeat (20) @(negedge clk);
    i_valid = 0;
    repeat (3) @(negedge clk);
    chk("cnt_sat", ovf_cnt0, 15);
    i_valid = 1; i_data = 16'h7FFF;
    @(negedge clk);
    i_valid = 0;
    @(negedge clk);
    chk("clr_pending", o_valid0 && o_ovf0, 1);
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
    chk("clr_prio0", ovf_cnt0, 0);
    chk("clr_prio2", ovf_cnt2, 0);

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      int r;
      i_valid = $urandom_range(0, 3) != 0;
      o_ready = $urandom_range(0, 3) != 0;
      cnt_clr = $urandom_range(0, 31) == 0;
      r = $urandom_range(0, 3);
      s = $urandom_range(8170, 8210);
      if ($urandom_range(0, 1) == 1) s = -s;
      if (r == 0) i_data = 16'($urandom);
      else if (r == 1) i_data = 16'(s);
      else if (r == 2) i_data = $urandom_range(0, 1) == 1 ? 16'h7FFF : 16'h8000;
      else i_data = 16'($urandom_range(0, 40)) - 16'd20;
      @(negedge clk);
    end
    i_valid = 0; cnt_clr = 0; o_ready = 1;
    repeat (4) @(negedge clk);
    chk("drain", sq.size(), 0);

    // reset with both stages full and output stalled
    i_valid = 1; i_data = 16'h7FFF; o_ready = 1;
    @(negedge clk);
    o_ready = 0;
    repeat (3) @(negedge clk);
    chk("pre_rst_full", {o_valid0, i_ready0}, 2'b10);
    rst = 1; i_valid = 0;
    @(negedge clk);
    chk("mid_rst_v", {o_valid0, o_valid1, o_valid2}, 0);
    chk("mid_rst_cnt", ovf_cnt0, 0);
    chk("mid_rst_rdy", {i_ready0, i_ready1, i_ready2}, 3'b111);
    rst = 0; o_ready = 1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_valid0) stale++;
    end
    chk("no_stale", stale, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
